// File: rtl/obj_compositor_pkg.sv
// Shared constants for the object compositor: colour and sprite-sheet
// geometry, the default transparency key, and the idle level of the syncs.
package obj_compositor_pkg;

  localparam int COLOR_W       = 12;
  localparam int SHEET_W       = 320;
  localparam int SPRITE_ADDR_W = 17;

  localparam logic [COLOR_W-1:0] KEY_COLOR_DEF = 12'h0F0;

  // VGA syncs are active low, so the idle level is high.
  localparam logic SYNC_IDLE = 1'b1;

  // Width of an object index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obj_compositor_priority_sel.sv
// Fixed-priority encoder: the lowest-numbered asserted enable wins.
module obj_priority_sel
  import obj_compositor_pkg::*;
#(
  parameter int N_OBJ = 4,
  parameter int IDX_W = idx_width(N_OBJ)
) (
  input  logic [N_OBJ-1:0] en,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (en[i]) idx = IDX_W'(i);
    end
    hit = |en;
  end

endmodule

// File: rtl/obj_compositor.sv
// Object compositor: picks the winning object per pixel, fetches one texel
// from the shared sprite memory, applies the transparency key and falls back
// to the background colour. Syncs and valid ride along so every pixel leaves
// exactly ROM_LAT+2 clocks after it arrives.
//
// Optional build macro OBJ_COMPOSITOR_HIGHLIGHT_EN: adds a vsync-edge frame
// counter and inverts opaque texels of objects selected in hl_sel during the
// odd 2^BLINK_SHIFT-frame half of the blink period.
module obj_compositor
  import obj_compositor_pkg::*;
#(
  parameter int                 N_OBJ       = 4,
  parameter int                 ADDR_W      = SPRITE_ADDR_W,
  parameter int                 ROM_LAT     = 1,
  parameter logic [COLOR_W-1:0] KEY_COLOR   = KEY_COLOR_DEF,
  parameter int                 BLINK_SHIFT = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic [N_OBJ-1:0]          obj_en,
  input  logic [N_OBJ*ADDR_W-1:0]   obj_addr,
  input  logic [COLOR_W-1:0]        bg_color,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [COLOR_W-1:0]        mem_data,
  input  logic [N_OBJ-1:0]          hl_sel,
  output logic [COLOR_W-1:0]        rgb,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      valid_out
);

  localparam int IDX_W = idx_width(N_OBJ);

  // Per-pixel sideband that travels alongside the memory read.
  typedef struct packed {
    logic               hit;
    logic [IDX_W-1:0]   idx;
    logic [COLOR_W-1:0] bg;
    logic               valid;
    logic               hs;
    logic               vs;
  } sb_t;

  function automatic sb_t sb_idle();
    sb_t s;
    s    = '0;
    s.hs = SYNC_IDLE;
    s.vs = SYNC_IDLE;
    return s;
  endfunction

  logic [N_OBJ-1:0]   en_gated;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_hit;
  logic [ADDR_W-1:0]  mem_addr_d, mem_addr_q;
  sb_t                s0_d, s0_q;
  sb_t                pipe_d [ROM_LAT];
  sb_t                pipe_q [ROM_LAT];
  sb_t                so;
  logic [COLOR_W-1:0] rgb_d, rgb_q;
  logic               hs_d, hs_q, vs_d, vs_q, vo_d, vo_q;
  logic               hl_now;

  // Objects cannot win during blanking, so blanking never fetches.
  assign en_gated = obj_en & {N_OBJ{valid_in}};

  obj_priority_sel #(.N_OBJ(N_OBJ), .IDX_W(IDX_W)) u_sel (
    .en  (en_gated),
    .idx (sel_idx),
    .hit (sel_hit)
  );

  // S0: issue the single fetch for the winner and capture the sideband.
  always_comb begin
    mem_addr_d = sel_hit ? obj_addr[int'(sel_idx)*ADDR_W +: ADDR_W] : '0;
    s0_d       = sb_idle();
    s0_d.hit   = sel_hit;
    s0_d.idx   = sel_idx;
    s0_d.bg    = bg_color;
    s0_d.valid = valid_in;
    s0_d.hs    = hsync_in;
    s0_d.vs    = vsync_in;
  end

  // S1..S_ROM_LAT: delay the sideband to meet the returning texel.
  always_comb begin
    pipe_d[0] = s0_q;
    for (int i = 1; i < ROM_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  assign so = pipe_q[ROM_LAT-1];

`ifdef OBJ_COMPOSITOR_HIGHLIGHT_EN
  logic [BLINK_SHIFT:0] frame_d, frame_q;
  logic                 vs_prev_d, vs_prev_q;

  // Count frames on vsync falling edges; the top bit is the blink phase.
  always_comb begin
    frame_d   = frame_q;
    vs_prev_d = vsync_in;
    if (vs_prev_q && !vsync_in) frame_d = frame_q + (BLINK_SHIFT+1)'(1);
  end

  // Frame counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q   <= '0;
      vs_prev_q <= SYNC_IDLE;
    end else begin
      frame_q   <= frame_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  assign hl_now = hl_sel[so.idx] & frame_q[BLINK_SHIFT];
`else
  logic unused_hl;
  assign hl_now    = 1'b0;
  assign unused_hl = ^{hl_sel, so.idx};
`endif

  // SO: choose texel, background or black for the pixel leaving the pipe.
  always_comb begin
    rgb_d = '0;
    if (so.valid) begin
      if (so.hit && (mem_data != KEY_COLOR)) rgb_d = hl_now ? ~mem_data : mem_data;
      else                                   rgb_d = so.bg;
    end
    hs_d = so.hs;
    vs_d = so.vs;
    vo_d = so.valid;
  end

  // Pipeline registers; reset flushes every stage to blank, idle syncs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_q <= '0;
      s0_q       <= sb_idle();
      for (int i = 0; i < ROM_LAT; i++) pipe_q[i] <= sb_idle();
      rgb_q      <= '0;
      hs_q       <= SYNC_IDLE;
      vs_q       <= SYNC_IDLE;
      vo_q       <= 1'b0;
    end else begin
      mem_addr_q <= mem_addr_d;
      s0_q       <= s0_d;
      for (int i = 0; i < ROM_LAT; i++) pipe_q[i] <= pipe_d[i];
      rgb_q      <= rgb_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      vo_q       <= vo_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign rgb       = rgb_q;
  assign hsync_out = hs_q;
  assign vsync_out = vs_q;
  assign valid_out = vo_q;

endmodule

// File: tb/tb_obj_compositor.sv
// Self-checking bench for obj_compositor: directed scenarios plus a random
// pixel stream scored against a spec-level model of the compositor.
`timescale 1ns/1ps
module tb_obj_compositor;

  localparam int N       = 4;
  localparam int AW      = 17;
  localparam int LAT     = 1;
  localparam int LATENCY = LAT + 2;
  localparam int BS      = 1;
  localparam logic [11:0] KEY = 12'h0F0;
`ifdef OBJ_COMPOSITOR_HIGHLIGHT_EN
  localparam bit HL_BUILT = 1'b1;
`else
  localparam bit HL_BUILT = 1'b0;
`endif

  logic            clk, rst, valid_in, hsync_in, vsync_in;
  logic [N-1:0]    obj_en, hl_sel;
  logic [N*AW-1:0] obj_addr;
  logic [11:0]     bg_color, mem_data, rgb;
  logic [AW-1:0]   mem_addr;
  logic            hsync_out, vsync_out, valid_out;

  int checks = 0;
  int errors = 0;
  int tick_n = 0;

  logic [11:0] mem [0:(1<<AW)-1];
  logic [11:0] rd_pipe [LAT];

  // Scoreboard: expected {rgb, hsync, vsync, valid} and address, with due tick.
  logic [14:0]   exp_q[$];
  int            exp_due_q[$];
  logic [AW-1:0] addr_q[$];
  int            addr_due_q[$];

  obj_compositor #(
    .N_OBJ(N), .ADDR_W(AW), .ROM_LAT(LAT), .KEY_COLOR(KEY), .BLINK_SHIFT(BS)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .obj_en(obj_en), .obj_addr(obj_addr),
    .bg_color(bg_color), .mem_addr(mem_addr), .mem_data(mem_data),
    .hl_sel(hl_sel), .rgb(rgb), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .valid_out(valid_out)
  );

  // Clock and sprite memory with LAT-cycle read latency.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_data = rd_pipe[LAT-1];

  // ---------------- reference model ----------------
  function automatic logic [AW-1:0] model_addr(input logic v, input logic [N-1:0] en,
                                               input logic [N*AW-1:0] a);
    if (!v) return '0;
    for (int i = 0; i < N; i++) if (en[i]) return a[i*AW +: AW];
    return '0;
  endfunction

  function automatic logic [11:0] model_rgb(input logic v, input logic [N-1:0] en,
                                            input logic [N*AW-1:0] a, input logic [11:0] bg,
                                            input logic [N-1:0] hl, input int frame);
    logic [11:0] t;
    if (!v) return 12'h000;
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        t = mem[a[i*AW +: AW]];
        if (t == KEY) return bg;
        if (HL_BUILT && hl[i] && ((frame >> BS) & 1) == 1) return ~t;
        return t;
      end
    end
    return bg;
  endfunction

  function automatic logic [N*AW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    logic [N*AW-1:0] p;
    p = '0;
    p[0*AW +: AW] = AW'(a0);
    p[1*AW +: AW] = AW'(a1);
    p[2*AW +: AW] = AW'(a2);
    p[3*AW +: AW] = AW'(a3);
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    tick_n++;
  endtask

  task automatic drive(input logic v, input logic hs, input logic vs, input logic [N-1:0] en,
                       input logic [N*AW-1:0] a, input logic [11:0] bg);
    valid_in = v;
    hsync_in = hs;
    vsync_in = vs;
    obj_en   = en;
    obj_addr = a;
    bg_color = bg;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b1, 1'b1, '0, '0, 12'h000);
  endtask

  task automatic drive_random();
    drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 15) != 0,
          N'($urandom),
          pack4($urandom_range(0, 76799), $urandom_range(0, 76799),
                $urandom_range(0, 76799), $urandom_range(0, 76799)),
          12'($urandom));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [14:0] e0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_random();
      tick();
      checks++;
      if ({rgb, hsync_out, vsync_out, valid_out, mem_addr} !== {12'h000, 1'b1, 1'b1, 1'b0, 17'h0}) begin
        errors++;
        $display("FAIL reset_hold: got rgb=%h hs=%b vs=%b valid=%b addr=%h expected 000 1 1 0 0",
                 rgb, hsync_out, vsync_out, valid_out, mem_addr);
      end
    end
    rst = 1'b0;
    drive_random();
    e0 = {model_rgb(valid_in, obj_en, obj_addr, bg_color, hl_sel, 0), hsync_in, vsync_in, valid_in};
    for (int k = 1; k < LATENCY; k++) begin
      tick();
      drive_idle();
      checks++;
      if ({rgb, hsync_out, vsync_out, valid_out} !== {12'h000, 1'b1, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_release_%0d: got rgb=%h hs=%b vs=%b valid=%b expected 000 1 1 0",
                 k, rgb, hsync_out, vsync_out, valid_out);
      end
    end
    tick();
    checks++;
    if ({rgb, hsync_out, vsync_out, valid_out} !== e0) begin
      errors++;
      $display("FAIL reset_first_pixel: got %h expected %h", {rgb, hsync_out, vsync_out, valid_out}, e0);
    end
  endtask

  task automatic test_background();
    drive(1'b1, 1'b1, 1'b1, 4'b0000, pack4(11, 22, 33, 44), 12'h123);
    tick();
    drive_idle();
    checks++;
    if (mem_addr !== 17'h0) begin
      errors++;
      $display("FAIL bg_addr: got %h expected 0", mem_addr);
    end
    for (int k = 1; k < LATENCY; k++) tick();
    checks++;
    if (rgb !== 12'h123 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL bg_rgb: got rgb=%h valid=%b expected 123 1", rgb, valid_out);
    end
  endtask

  task automatic test_priority();
    mem[100] = 12'hF00;
    mem[200] = 12'h0FF;
    drive(1'b1, 1'b1, 1'b1, 4'b0110, pack4(7, 100, 200, 9), 12'h321);
    tick();
    drive_idle();
    checks++;
    if (mem_addr !== 17'd100) begin
      errors++;
      $display("FAIL prio_addr: got %0d expected 100", mem_addr);
    end
    for (int k = 1; k < LATENCY; k++) tick();
    checks++;
    if (rgb !== 12'hF00) begin
      errors++;
      $display("FAIL prio_rgb: got %h expected F00", rgb);
    end
  endtask

  task automatic test_transparency();
    mem[300] = KEY;
    mem[400] = 12'hABC;
    drive(1'b1, 1'b1, 1'b1, 4'b0011, pack4(300, 400, 0, 0), 12'h00F);
    tick();
    drive_idle();
    checks++;
    if (mem_addr !== 17'd300) begin
      errors++;
      $display("FAIL transp_addr: got %0d expected 300", mem_addr);
    end
    for (int k = 1; k < LATENCY; k++) tick();
    checks++;
    if (rgb !== 12'h00F) begin
      errors++;
      $display("FAIL transp_rgb: got %h expected 00F", rgb);
    end
  endtask

  task automatic test_blanking();
    drive_idle();
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'b0001, pack4(500, 0, 0, 0), 12'h777);
    tick();
    drive_idle();
    checks++;
    if (mem_addr !== 17'h0) begin
      errors++;
      $display("FAIL blank_addr: got %h expected 0", mem_addr);
    end
    for (int k = 2; k <= LATENCY + 1; k++) begin
      tick();
      if (k == LATENCY - 1) begin
        checks++;
        if ({hsync_out, vsync_out} !== 2'b11) begin
          errors++;
          $display("FAIL blank_sync_early: got %b%b expected 11", hsync_out, vsync_out);
        end
      end else if (k == LATENCY) begin
        checks++;
        if ({rgb, hsync_out, vsync_out, valid_out} !== {12'h000, 1'b0, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL blank_pixel: got rgb=%h hs=%b vs=%b valid=%b expected 000 0 0 0",
                   rgb, hsync_out, vsync_out, valid_out);
        end
      end else if (k == LATENCY + 1) begin
        checks++;
        if ({hsync_out, vsync_out} !== 2'b11) begin
          errors++;
          $display("FAIL blank_sync_late: got %b%b expected 11", hsync_out, vsync_out);
        end
      end
    end
  endtask

  task automatic test_highlight();
    logic [11:0] want;
    drive_idle();
    hl_sel = 4'b0001;
    mem[600] = 12'h0A5;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < LATENCY; k++) tick();
    for (int f = 0; f < 4; f++) begin
      if (f > 0) begin
        drive(1'b0, 1'b1, 1'b0, '0, '0, 12'h000);
        tick();
        drive_idle();
        tick();
      end
      drive(1'b1, 1'b1, 1'b1, 4'b0001, pack4(600, 0, 0, 0), 12'h456);
      tick();
      drive_idle();
      for (int k = 1; k < LATENCY; k++) tick();
      want = (HL_BUILT && f >= 2) ? 12'hF5A : 12'h0A5;
      checks++;
      if (rgb !== want) begin
        errors++;
        $display("FAIL highlight_frame%0d: got %h expected %h", f, rgb, want);
      end
    end
    hl_sel = '0;
  endtask

  task automatic test_random_stream();
    localparam int NR = 300;
    for (int c = 0; c < NR + LATENCY; c++) begin
      if (c < NR) drive_random();
      else        drive_idle();
      exp_q.push_back({model_rgb(valid_in, obj_en, obj_addr, bg_color, hl_sel, 0),
                       hsync_in, vsync_in, valid_in});
      exp_due_q.push_back(tick_n + LATENCY);
      addr_q.push_back(model_addr(valid_in, obj_en, obj_addr));
      addr_due_q.push_back(tick_n + 1);
      tick();
      if (addr_due_q.size() > 0 && addr_due_q[0] == tick_n) begin
        checks++;
        if (mem_addr !== addr_q[0]) begin
          errors++;
          $display("FAIL rand_addr@%0d: got %h expected %h", tick_n, mem_addr, addr_q[0]);
        end
        void'(addr_q.pop_front());
        void'(addr_due_q.pop_front());
      end
      if (exp_due_q.size() > 0 && exp_due_q[0] == tick_n) begin
        checks++;
        if ({rgb, hsync_out, vsync_out, valid_out} !== exp_q[0]) begin
          errors++;
          $display("FAIL rand_pixel@%0d: got %h expected %h", tick_n,
                   {rgb, hsync_out, vsync_out, valid_out}, exp_q[0]);
        end
        void'(exp_q.pop_front());
        void'(exp_due_q.pop_front());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst    = 1'b1;
    hl_sel = '0;
    drive_idle();
    for (int i = 0; i < (1 << AW); i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
    test_reset();
    test_background();
    test_priority();
    test_transparency();
    test_blanking();
    test_random_stream();
    test_highlight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
